mips_fetch_unit: RTL and testbench
==================================

// Module: mips_fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the multicycle MIPS core's ins_in port.
//  - Takes the word address from the core's PC output.
//  - Runs a req/ready handshake to a wait-stated instruction memory.
//  - Holds the fetched word stable for the core's instruction register.
//  - A single-entry last-fetch buffer skips memory when the same PC is re-fetched.
//  - A wait-cycle watchdog substitutes a NOP if memory never answers.
// PARAMETERS
//  AW       32        address width; PC is word-addressed (PC+1 = next instruction)
//  DW       32        instruction width
//  TIMEOUT  15        max WAIT cycles without mem_ready before abort (>=1)
//  NOP_INS  32'h0     word delivered on timeout (sll $0,$0,0)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous reset, active low
//  pc_in      in   AW  fetch address (from core PCOut)
//  fetch_req  in   1   start fetch; sampled only in IDLE
//  flush      in   1   invalidate last-fetch buffer (imem rewritten)
//  mem_rd     out  1   memory read request
//  mem_addr   out  AW  memory word address, stable while mem_rd=1
//  mem_rdata  in   DW  memory read data, valid when mem_ready=1
//  mem_ready  in   1   memory handshake completion
//  ins_out    out  DW  fetched instruction (to core ins_in), held until next capture
//  ins_valid  out  1   one-cycle pulse: ins_out updated this cycle
//  busy       out  1   1 whenever state != IDLE (core must hold IRWrite)
//  fetch_err  out  1   sticky timeout flag; cleared by next accepted fetch_req
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE; mem_rd, ins_valid, busy, fetch_err = 0.
//   - mem_addr, ins_out = 0; buffer invalid; wait counter = 0.
//   - mem_rd drops immediately, including mid-WAIT; the pending transaction is abandoned.
//  FSM: IDLE -> WAIT -> DONE -> IDLE; IDLE -> DONE on buffer hit.
//   IDLE, fetch_req=1 accepted:
//    - fetch_err cleared.
//    - Hit (buf_valid && pc_in==buf_addr): ins_out<=buf_ins -> DONE. No mem access; 1-cycle latency.
//    - Miss: mem_addr<=pc_in, mem_rd<=1, cnt<=0 -> WAIT.
//   WAIT:
//    - mem_rd held 1; mem_addr is constant.
//    - mem_ready=1: ins_out<=mem_rdata; buf_addr<=mem_addr; buf_ins<=mem_rdata; buf_valid<=1;
//      mem_rd<=0 -> DONE.
//    - else if cnt==TIMEOUT-1: ins_out<=NOP_INS; fetch_err<=1; buf_valid<=0; mem_rd<=0 -> DONE.
//    - else cnt<=cnt+1. The counter saturates and never wraps.
//    - mem_ready on the timeout cycle counts as success; ready wins.
//   DONE:
//    - ins_valid=1 for exactly this cycle -> IDLE.
//    - fetch_req here is ignored, not queued. It must be re-asserted in IDLE.
//  Latency (fetch_req edge to ins_valid): hit = 1 cycle; miss with ready in first WAIT cycle = 2 cycles.
//  mem_ready outside WAIT: ignored.
//  flush:
//   - Clears buf_valid on any cycle.
//   - If coincident with WAIT capture, flush wins for buf_valid, but ins_out is still delivered.
//   - If coincident with an IDLE lookup, the lookup is treated as a miss.
//  busy is registered; it is 1 the cycle after acceptance through DONE inclusive.
// TESTING
//  T1 reset: rst=0 mid-WAIT (mem_rd=1) -> mem_rd=0 same cycle; all outputs 0; state IDLE after release.
//  T2 miss: pc_in=0x10, fetch_req, mem_ready after 3 WAIT cycles, rdata=0x8C220004
//     -> mem_addr=0x10 held; ins_out=0x8C220004; ins_valid 1 cycle; fetch_err=0.
//  T3 hit: refetch pc_in=0x10 -> ins_valid next cycle; mem_rd never asserts; ins_out=0x8C220004.
//  T4 flush: flush, then fetch pc_in=0x10 -> mem_rd asserted (miss) despite same address.
//  T5 timeout: pc_in=0x20, mem_ready held 0 -> after 15 WAIT cycles ins_out=0x0, fetch_err=1;
//     next fetch_req clears fetch_err.
//  T6 edge: mem_ready on cycle TIMEOUT-1 with rdata=0x1234 -> ins_out=0x1234, fetch_err=0;
//     fetch_req held through DONE -> exactly one new fetch starts, from IDLE.

Source files
------------

// File: rtl/mips_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit_if
// Purpose : memory-side bus between the MIPS fetch stage and the wait-stated
//           instruction memory. It carries a req/ready read handshake.
// Signals :
//   memRd     fetch -> mem  read request, held high until memReady
//   memAddr   fetch -> mem  word address, stable while memRd is high
//   memRdata  mem -> fetch  read data, valid when memReady is high
//   memReady  mem -> fetch  handshake completion
// Modports: master (fetch unit side), slave (memory side)
// ---------------------------------------------------------------------------
interface mips_fetch_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          memRd;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memRdata;
  logic          memReady;

  modport master (
    output memRd,
    output memAddr,
    input  memRdata,
    input  memReady
  );

  modport slave (
    input  memRd,
    input  memAddr,
    output memRdata,
    output memReady
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit
// Purpose : instruction fetch stage for the multicycle MIPS core. It takes the
//           word-addressed PC and fetches the instruction through a req/ready
//           handshake. The fetched word is held for the core's instruction
//           register. A single-entry last-fetch buffer skips memory when the
//           same PC is fetched again. A watchdog substitutes NOP_INS if the
//           memory never answers.
// Ports   :
//   clk_i        rising-edge clock
//   rst_ni       asynchronous reset, active low
//   pc_i         fetch address from the core PC
//   fetchReq_i   start a fetch; sampled only while idle
//   flush_i      invalidate the last-fetch buffer
//   mem          memory bus (mips_fetch_unit_if.master)
//   insOut_o     fetched instruction, held until the next capture
//   insValid_o   one-cycle pulse when insOut_o has just been updated
//   busy_o       high whenever a fetch is in progress
//   fetchErr_o   sticky timeout flag, cleared by the next accepted fetch
// ---------------------------------------------------------------------------
module mips_fetch_unit #(
  parameter int              AW      = 32,
  parameter int              DW      = 32,
  parameter int              TIMEOUT = 15,
  parameter logic [DW-1:0]   NOP_INS = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [AW-1:0]      pc_i,
  input  logic               fetchReq_i,
  input  logic               flush_i,
  mips_fetch_unit_if.master  mem,
  output logic [DW-1:0]      insOut_o,
  output logic               insValid_o,
  output logic               busy_o,
  output logic               fetchErr_o
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          memRd_q, memRd_d;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic [DW-1:0] insOut_q, insOut_d;
  logic          insValid_q, insValid_d;
  logic          busy_q, busy_d;
  logic          fetchErr_q, fetchErr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bufValid_q, bufValid_d;
  logic [AW-1:0] bufAddr_q, bufAddr_d;
  logic [DW-1:0] bufIns_q, bufIns_d;
  logic          bufHit;

  // A coincident flush turns an otherwise valid buffer lookup into a miss.
  // The memory has just been rewritten, so the buffered copy cannot be trusted.
  assign bufHit = bufValid_q && !flush_i && (pc_i == bufAddr_q);

  // State and output registers. Reset is asynchronous so that memRd drops
  // immediately, even in the middle of a wait. Any pending memory
  // transaction is simply abandoned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      memRd_q    <= 1'b0;
      memAddr_q  <= '0;
      insOut_q   <= '0;
      insValid_q <= 1'b0;
      busy_q     <= 1'b0;
      fetchErr_q <= 1'b0;
      cnt_q      <= '0;
      bufValid_q <= 1'b0;
      bufAddr_q  <= '0;
      bufIns_q   <= '0;
    end else begin
      state_q    <= state_d;
      memRd_q    <= memRd_d;
      memAddr_q  <= memAddr_d;
      insOut_q   <= insOut_d;
      insValid_q <= insValid_d;
      busy_q     <= busy_d;
      fetchErr_q <= fetchErr_d;
      cnt_q      <= cnt_d;
      bufValid_q <= bufValid_d;
      bufAddr_q  <= bufAddr_d;
      bufIns_q   <= bufIns_d;
    end
  end

  // Next-state logic for the IDLE -> WAIT -> DONE -> IDLE sequence, with a
  // shortcut from IDLE straight to DONE on a buffer hit. In WAIT a ready
  // response beats the watchdog, even on its final cycle. The wait counter
  // saturates rather than wrapping. Flush is applied last, so it overrides
  // a buffer refill in the same cycle. The instruction itself is still
  // delivered in that case. busy and insValid are registered copies of the
  // decoded next state. fetchReq seen in DONE is ignored and must be raised
  // again once the unit is back in IDLE.
  always_comb begin
    state_d    = state_q;
    memRd_d    = memRd_q;
    memAddr_d  = memAddr_q;
    insOut_d   = insOut_q;
    fetchErr_d = fetchErr_q;
    cnt_d      = cnt_q;
    bufValid_d = bufValid_q;
    bufAddr_d  = bufAddr_q;
    bufIns_d   = bufIns_q;

    case (state_q)
      S_IDLE: begin
        if (fetchReq_i) begin
          fetchErr_d = 1'b0;
          if (bufHit) begin
            insOut_d = bufIns_q;
            state_d  = S_DONE;
          end else begin
            memAddr_d = pc_i;
            memRd_d   = 1'b1;
            cnt_d     = '0;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem.memReady) begin
          insOut_d   = mem.memRdata;
          bufAddr_d  = memAddr_q;
          bufIns_d   = mem.memRdata;
          bufValid_d = 1'b1;
          memRd_d    = 1'b0;
          state_d    = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          insOut_d   = NOP_INS;
          fetchErr_d = 1'b1;
          bufValid_d = 1'b0;
          memRd_d    = 1'b0;
          state_d    = S_DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        memRd_d = 1'b0;
      end
    endcase

    if (flush_i) begin
      bufValid_d = 1'b0;
    end

    insValid_d = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  // Everything visible outside is driven straight from registers, so the
  // core and the memory never see combinational glitches.
  assign mem.memRd   = memRd_q;
  assign mem.memAddr = memAddr_q;
  assign insOut_o    = insOut_q;
  assign insValid_o  = insValid_q;
  assign busy_o      = busy_q;
  assign fetchErr_o  = fetchErr_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_unit
// Purpose : self-checking bench for mips_fetch_unit. A memory responder
//           answers reads after a programmable number of wait cycles, or
//           never. A transaction-level model of the last-fetch buffer
//           predicts the outcome of each fetch: hit or miss, latency,
//           instruction word and error flag.
// ---------------------------------------------------------------------------
module tb_mips_fetch_unit;

  localparam int TIMEOUT = 15;
  localparam int NEVER   = 99;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        fetchReq;
  logic        flush;
  logic [31:0] insOut;
  logic        insValid;
  logic        busy;
  logic        fetchErr;

  int testsRun    = 0;
  int testsFailed = 0;

  int          readyDelay = NEVER;
  logic [31:0] respData   = '0;

  bit          mBufValid = 1'b0;
  logic [31:0] mBufAddr  = '0;
  logic [31:0] mBufIns   = '0;

  mips_fetch_unit_if #(.AW(32), .DW(32)) memBus ();

  mips_fetch_unit #(
    .AW(32), .DW(32), .TIMEOUT(TIMEOUT), .NOP_INS(32'h0)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pc_i       (pc),
    .fetchReq_i (fetchReq),
    .flush_i    (flush),
    .mem        (memBus),
    .insOut_o   (insOut),
    .insValid_o (insValid),
    .busy_o     (busy),
    .fetchErr_o (fetchErr)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 clk = ~clk;

  // Memory responder. While a read is pending it raises memReady on the
  // programmed wait cycle, counting from zero. At all other times it drives
  // random noise on memReady and memRdata. The fetch unit must ignore
  // that noise.
  initial begin
    int waitCnt;
    waitCnt = 0;
    memBus.memReady = 1'b0;
    memBus.memRdata = '0;
    forever begin
      @(negedge clk);
      if (memBus.memRd) begin
        memBus.memReady = (waitCnt == readyDelay);
        memBus.memRdata = (waitCnt == readyDelay) ? respData : $urandom;
        waitCnt++;
      end else begin
        waitCnt = 0;
        memBus.memReady = 1'($urandom_range(0, 1));
        memBus.memRdata = $urandom;
      end
    end
  end

  // One complete fetch, checked against the buffer model.
  // flushBefore : a separate flush cycle happens before the request.
  // flushAccept : flush is raised in the same cycle as the request.
  // flushCap    : flush is raised in the cycle where memory answers.
  // holdReq     : fetchReq stays high through DONE. It must not start
  //               a second fetch there.
  task automatic runFetch(input string name, input logic [31:0] addr,
                          input int delay, input logic [31:0] data,
                          input bit flushBefore, input bit flushAccept,
                          input bit flushCap, input bit holdReq);
    bit          expHit, capFlush, done, sawRd, addrBad, busyBad, errClrBad;
    int          expLat, lat;
    logic [31:0] expIns;
    logic        expErr;

    @(negedge clk);
    if (flushBefore) begin
      flush = 1'b1;
      @(negedge clk);
      flush     = 1'b0;
      mBufValid = 1'b0;
    end

    expHit   = mBufValid && !flushAccept && (addr == mBufAddr);
    capFlush = flushCap && !expHit && (delay < TIMEOUT);
    if (flushAccept) mBufValid = 1'b0;
    if (expHit) begin
      expLat = 1;
      expIns = mBufIns;
      expErr = 1'b0;
    end else if (delay < TIMEOUT) begin
      expLat    = delay + 2;
      expIns    = data;
      expErr    = 1'b0;
      mBufValid = !capFlush;
      mBufAddr  = addr;
      mBufIns   = data;
    end else begin
      expLat    = TIMEOUT + 1;
      expIns    = 32'h0;
      expErr    = 1'b1;
      mBufValid = 1'b0;
    end

    readyDelay = delay;
    respData   = data;
    pc         = addr;
    fetchReq   = 1'b1;
    flush      = flushAccept;
    lat = 0; done = 0; sawRd = 0; addrBad = 0; busyBad = 0; errClrBad = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!holdReq) fetchReq = 1'b0;
      flush = capFlush && (lat == delay + 1);
      pc    = $urandom;
      if (lat == 1 && fetchErr !== 1'b0) errClrBad = 1;
      if (memBus.memRd === 1'b1) begin
        sawRd = 1;
        if (memBus.memAddr !== addr) addrBad = 1;
      end
      if (busy !== 1'b1) busyBad = 1;
      if (insValid === 1'b1) done = 1;
    end
    flush = 1'b0;

    testsRun++;
    if (!done || lat != expLat) begin
      testsFailed++;
      $display("[TB] FAIL %s latency: got %0d (done=%0d) expected %0d", name, lat, done, expLat);
    end
    testsRun++;
    if (insOut !== expIns) begin
      testsFailed++;
      $display("[TB] FAIL %s insOut: got %h expected %h", name, insOut, expIns);
    end
    testsRun++;
    if (fetchErr !== expErr) begin
      testsFailed++;
      $display("[TB] FAIL %s fetchErr: got %b expected %b", name, fetchErr, expErr);
    end
    testsRun++;
    if (sawRd !== !expHit) begin
      testsFailed++;
      $display("[TB] FAIL %s memRd seen: got %0d expected %0d", name, sawRd, !expHit);
    end
    testsRun++;
    if (addrBad || busyBad || errClrBad) begin
      testsFailed++;
      $display("[TB] FAIL %s in-flight: addrBad=%0d busyBad=%0d errNotCleared=%0d expected all 0",
               name, addrBad, busyBad, errClrBad);
    end

    @(negedge clk);
    fetchReq = 1'b0;
    testsRun++;
    if (insValid !== 1'b0 || busy !== 1'b0 || memBus.memRd !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s after DONE: insValid=%b busy=%b memRd=%b expected 0 0 0",
               name, insValid, busy, memBus.memRd);
    end
    testsRun++;
    if (insOut !== expIns || fetchErr !== expErr) begin
      testsFailed++;
      $display("[TB] FAIL %s hold: insOut=%h fetchErr=%b expected %h %b",
               name, insOut, fetchErr, expIns, expErr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetchReq = 1'b0; flush = 1'b0; pc = '0;
    #12;
    testsRun++;
    if (memBus.memRd !== 1'b0 || memBus.memAddr !== 32'h0 || insOut !== 32'h0 ||
        insValid !== 1'b0 || busy !== 1'b0 || fetchErr !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset values: memRd=%b memAddr=%h insOut=%h insValid=%b busy=%b fetchErr=%b expected all 0",
               memBus.memRd, memBus.memAddr, insOut, insValid, busy, fetchErr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mBufValid = 1'b0;
  endtask

  task automatic test_miss();
    runFetch("miss_0x10", 32'h10, 3, 32'h8C220004, 0, 0, 0, 0);
  endtask

  task automatic test_hit();
    runFetch("hit_0x10", 32'h10, 0, 32'hDEADBEEF, 0, 0, 0, 0);
  endtask

  task automatic test_flush();
    runFetch("flush_before", 32'h10, 1, 32'hAC220008, 1, 0, 0, 0);
    runFetch("flush_at_accept", 32'h10, 2, 32'h20420001, 0, 1, 0, 0);
    runFetch("flush_at_capture", 32'h14, 0, 32'h3C011001, 0, 0, 1, 0);
    runFetch("after_cap_flush", 32'h14, 1, 32'h3C011002, 0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    runFetch("timeout_0x20", 32'h20, NEVER, 32'h0, 0, 0, 0, 0);
    runFetch("err_clear", 32'h10, 0, 32'h8C230008, 0, 0, 0, 0);
  endtask

  task automatic test_edge();
    runFetch("ready_last_cycle", 32'h30, TIMEOUT - 1, 32'h1234, 0, 0, 0, 1);
    runFetch("ready_second_last", 32'h31, TIMEOUT - 2, 32'h5678, 0, 0, 0, 1);
    runFetch("hit_after_edge", 32'h31, 0, 32'h0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_midwait();
    runFetch("prefill_0x44", 32'h44, 0, 32'h8C440000, 0, 0, 0, 0);
    @(negedge clk);
    readyDelay = NEVER;
    pc         = 32'h48;
    fetchReq   = 1'b1;
    @(negedge clk);
    fetchReq = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++;
    if (memBus.memRd !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midwait memRd before reset: got %b expected 1", memBus.memRd);
    end
    #2 rst_n = 1'b0;
    #1;
    testsRun++;
    if (memBus.memRd !== 1'b0 || memBus.memAddr !== 32'h0 || insOut !== 32'h0 ||
        insValid !== 1'b0 || busy !== 1'b0 || fetchErr !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midwait async reset: memRd=%b memAddr=%h insOut=%h insValid=%b busy=%b fetchErr=%b expected all 0",
               memBus.memRd, memBus.memAddr, insOut, insValid, busy, fetchErr);
    end
    mBufValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0 || memBus.memRd !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midwait after release: busy=%b memRd=%b expected 0 0", busy, memBus.memRd);
    end
    runFetch("post_reset_miss_0x44", 32'h44, 1, 32'h8C440004, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int          r, delay;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       addr = 32'h10;
        1:       addr = 32'h11;
        2:       addr = 32'h20;
        default: addr = $urandom;
      endcase
      r = $urandom_range(0, 19);
      if (r < 12)      delay = r % 6;
      else if (r < 15) delay = TIMEOUT - 1 - (r % 2);
      else if (r < 17) delay = NEVER;
      else             delay = r % 3;
      runFetch("random", addr, delay, $urandom,
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end
  endtask

  // Scenario sequence. The directed cases come first. Randomised
  // back-to-back fetches follow and mix hits, misses, flushes and timeouts.
  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_flush();
    test_timeout();
    test_edge();
    test_reset_midwait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
